branch_resolution_queue: RTL and testbench

- Sits directly downstream of the correlating branch predictor.
- Holds each issued prediction (PC, predicted direction) in order until the actual branch outcome resolves.
- On resolution, pairs the outcome with the oldest prediction and emits a registered update (PC, actual result) for the predictor's training port, plus a mispredict flag.
- Keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_pkg.sv | 15 +
 rtl/branch_pred_fifo.sv | 64 ++++++
 rtl/branch_resolution_queue.sv | 113 +++++++++++
 tb/tb_branch_resolution_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch resolution queue: the queued prediction entry
// and a saturating increment helper for the statistics counters.
package branch_pkg;
    localparam int PCW = 32;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic           taken;
    } pred_entry_t;

    // Callers pass counters zero-extended to 32 bits; max is the all-ones value of the counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] count, input logic [31:0] max);
        return (count >= max) ? max : count + 32'd1;
    endfunction
endpackage

// File: rtl/branch_pred_fifo.sv
// In-order store of issued predictions. Pointers carry an extra wrap bit so
// full and empty fall out of the pointer difference.
module branch_pred_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  pred_entry_t              din,
    output pred_entry_t              dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    pred_entry_t mem_q [DEPTH];
    pred_entry_t mem_d [DEPTH];
    logic        push_ok, pop_ok;

    assign occupancy = wptr_q - rptr_q;
    assign full      = (occupancy == (AW+1)'(DEPTH));
    assign empty     = (wptr_q == rptr_q);
    assign push_ok   = push && !full && !flush;
    assign pop_ok    = pop && !empty && !flush;
    assign dout      = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wptr_q[AW-1:0]] = din;
                wptr_d = wptr_q + 1'b1;
            end
            if (pop_ok)
                rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/branch_resolution_queue.sv
// Pairs resolved branch outcomes with the oldest outstanding prediction and
// emits a registered training update plus saturating statistics.
module branch_resolution_queue
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PCW   = branch_pkg::PCW,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     pred_valid,
    input  logic [PCW-1:0]           pred_PC,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     upd_valid,
    output logic [PCW-1:0]           upd_PC,
    output logic                     upd_result,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNTW-1:0]          branch_count,
    output logic [CNTW-1:0]          mispredict_count,
    output logic                     overflow_err,
    output logic                     underflow_err
);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNTW) - 64'd1);

    pred_entry_t fifo_din, head;
    logic        full, empty, pop_ok, miss;

    logic            upd_valid_q, upd_valid_d;
    logic [PCW-1:0]  upd_pc_q, upd_pc_d;
    logic            upd_result_q, upd_result_d;
    logic            mispredict_q, mispredict_d;
    logic [CNTW-1:0] branch_count_q, branch_count_d;
    logic [CNTW-1:0] mispredict_count_q, mispredict_count_d;
    logic            overflow_err_q, overflow_err_d;
    logic            underflow_err_q, underflow_err_d;

    assign fifo_din.pc    = pred_PC;
    assign fifo_din.taken = pred_taken;

    branch_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (pred_valid),
        .pop       (res_valid),
        .din       (fifo_din),
        .dout      (head),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    assign pred_ready = !full;
    assign pop_ok     = res_valid && !empty && !flush;
    assign miss       = res_taken ^ head.taken;

    always_comb begin
        upd_valid_d        = pop_ok;
        upd_pc_d           = upd_pc_q;
        upd_result_d       = upd_result_q;
        mispredict_d       = mispredict_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        // Flush suppresses both error flags along with the dropped push/pop.
        overflow_err_d     = overflow_err_q  || (pred_valid && full  && !flush);
        underflow_err_d    = underflow_err_q || (res_valid  && empty && !flush);
        if (pop_ok) begin
            upd_pc_d       = head.pc;
            upd_result_d   = res_taken;
            mispredict_d   = miss;
            branch_count_d = CNTW'(sat_inc(32'(branch_count_q), CNT_MAX));
            if (miss)
                mispredict_count_d = CNTW'(sat_inc(32'(mispredict_count_q), CNT_MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_valid_q        <= 1'b0;
            upd_pc_q           <= '0;
            upd_result_q       <= 1'b0;
            mispredict_q       <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            overflow_err_q     <= 1'b0;
            underflow_err_q    <= 1'b0;
        end else begin
            upd_valid_q        <= upd_valid_d;
            upd_pc_q           <= upd_pc_d;
            upd_result_q       <= upd_result_d;
            mispredict_q       <= mispredict_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            overflow_err_q     <= overflow_err_d;
            underflow_err_q    <= underflow_err_d;
        end
    end

    assign upd_valid        = upd_valid_q;
    assign upd_PC           = upd_pc_q;
    assign upd_result       = upd_result_q;
    assign mispredict       = mispredict_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
    assign overflow_err     = overflow_err_q;
    assign underflow_err    = underflow_err_q;
endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed bench: stimulus pushes expected updates into a scoreboard queue,
// a negedge monitor pops and compares whenever upd_valid is seen.
module tb_branch_resolution_queue;
    localparam int DEPTH = 4;
    localparam int PCW   = 32;
    localparam int CNTW  = 4;

    logic            clk = 1'b0;
    logic            reset, flush, pred_valid, pred_taken, res_valid, res_taken;
    logic [PCW-1:0]  pred_PC;
    logic            pred_ready, upd_valid, upd_result, mispredict;
    logic [PCW-1:0]  upd_PC;
    logic [2:0]      occupancy;
    logic [CNTW-1:0] branch_count, mispredict_count;
    logic            overflow_err, underflow_err;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic           result;
        logic           miss;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    branch_resolution_queue #(.DEPTH(DEPTH), .PCW(PCW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .pred_valid(pred_valid), .pred_PC(pred_PC), .pred_taken(pred_taken),
        .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid), .upd_PC(upd_PC), .upd_result(upd_result),
        .mispredict(mispredict), .occupancy(occupancy),
        .branch_count(branch_count), .mispredict_count(mispredict_count),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every upd_valid pulse must match the oldest expected update.
    always @(negedge clk) begin
        if (upd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_upd: got upd_PC 0x%0h expected no update", upd_PC);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("upd_PC", 64'(upd_PC), 64'(e.pc));
                chk("upd_result", 64'(upd_result), 64'(e.result));
                chk("mispredict", 64'(mispredict), 64'(e.miss));
            end
        end
    end

    task automatic idle();
        reset = 0; flush = 0; pred_valid = 0; pred_PC = '0; pred_taken = 0;
        res_valid = 0; res_taken = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
    endtask

    task automatic push(input logic [PCW-1:0] pc, input logic t);
        pred_valid = 1; pred_PC = pc; pred_taken = t;
    endtask

    task automatic resolve(input logic t);
        res_valid = 1; res_taken = t;
    endtask

    task automatic expect_upd(input logic [PCW-1:0] pc, input logic r, input logic m);
        exp_t e;
        e.pc = pc; e.result = r; e.miss = m;
        sb.push_back(e);
    endtask

    logic [PCW-1:0] pcs [12];
    logic           tks [12];

    initial begin
        idle();
        #1;
        do_reset();
        step();
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_pred_ready", 64'(pred_ready), 64'd1);
        chk("rst_upd_valid", 64'(upd_valid), 64'd0);
        chk("rst_counts", 64'({branch_count, mispredict_count}), 64'd0);
        chk("rst_errs", 64'({overflow_err, underflow_err}), 64'd0);

        // In-order resolution with one mispredict.
        push(32'h100, 1); step();
        push(32'h104, 0); step();
        push(32'h108, 1); step();
        chk("t1_occ3", 64'(occupancy), 64'd3);
        resolve(1); expect_upd(32'h100, 1, 0); step();
        resolve(1); expect_upd(32'h104, 1, 1); step();
        resolve(1); expect_upd(32'h108, 1, 0); step();
        step();
        chk("t1_branch_count", 64'(branch_count), 64'd3);
        chk("t1_mispredict_count", 64'(mispredict_count), 64'd1);

        // Fill, overflow, drain.
        do_reset();
        push(32'h10, 0); step();
        push(32'h14, 1); step();
        push(32'h18, 0); step();
        push(32'h1C, 1); step();
        chk("t2_full_ready", 64'(pred_ready), 64'd0);
        chk("t2_full_occ", 64'(occupancy), 64'd4);
        chk("t2_no_ovf_yet", 64'(overflow_err), 64'd0);
        push(32'h20, 1); step();
        chk("t2_ovf", 64'(overflow_err), 64'd1);
        chk("t2_occ_after_drop", 64'(occupancy), 64'd4);
        resolve(0); expect_upd(32'h10, 0, 0); step();
        resolve(1); expect_upd(32'h14, 1, 0); step();
        resolve(0); expect_upd(32'h18, 0, 0); step();
        resolve(1); expect_upd(32'h1C, 1, 0); step();
        step();
        chk("t2_empty", 64'(occupancy), 64'd0);
        chk("t2_ovf_sticky", 64'(overflow_err), 64'd1);

        // Resolve while empty.
        do_reset();
        resolve(1); step();
        chk("t3_no_upd", 64'(upd_valid), 64'd0);
        chk("t3_underflow", 64'(underflow_err), 64'd1);
        chk("t3_counts", 64'({branch_count, mispredict_count}), 64'd0);
        step();
        chk("t3_underflow_sticky", 64'(underflow_err), 64'd1);

        // Steady state at occupancy 2 with wrap-around.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            pcs[i] = 32'h300 + 32'(4 * i);
            tks[i] = (i % 3 == 0);
        end
        push(pcs[0], tks[0]); step();
        push(pcs[1], tks[1]); step();
        for (int i = 0; i < 10; i++) begin
            push(pcs[i+2], tks[i+2]);
            resolve(1);
            expect_upd(pcs[i], 1'b1, !tks[i]);
            step();
            chk("t4_occ2", 64'(occupancy), 64'd2);
        end
        resolve(0); expect_upd(pcs[10], 0, tks[10]); step();
        resolve(0); expect_upd(pcs[11], 0, tks[11]); step();
        step();
        chk("t4_drained", 64'(occupancy), 64'd0);

        // Flush with simultaneous push and resolve.
        do_reset();
        push(32'h500, 1); step();
        push(32'h504, 0); step();
        push(32'h508, 1); step();
        push(32'h50C, 0); step();
        resolve(1); expect_upd(32'h500, 1, 0); step();
        chk("t5_occ3", 64'(occupancy), 64'd3);
        flush = 1; push(32'h510, 1); resolve(0); step();
        chk("t5_flush_occ", 64'(occupancy), 64'd0);
        chk("t5_flush_no_upd", 64'(upd_valid), 64'd0);
        chk("t5_flush_bc", 64'(branch_count), 64'd1);
        chk("t5_flush_mc", 64'(mispredict_count), 64'd0);
        chk("t5_flush_errs", 64'({overflow_err, underflow_err}), 64'd0);
        push(32'h200, 1); step();
        resolve(0); expect_upd(32'h200, 0, 1); step();
        step();
        chk("t5_bc_after", 64'(branch_count), 64'd2);

        // Counter saturation and mid-stream reset.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            push(32'h400 + 32'(4 * i), 1); step();
            resolve(0); expect_upd(32'h400 + 32'(4 * i), 0, 1); step();
        end
        step();
        chk("t6_bc_sat", 64'(branch_count), 64'd15);
        chk("t6_mc_sat", 64'(mispredict_count), 64'd15);
        resolve(1); step();
        chk("t6_underflow", 64'(underflow_err), 64'd1);
        push(32'h600, 1); step();
        push(32'h604, 0); step();
        reset = 1; resolve(1); step();
        chk("t6_rst_occ", 64'(occupancy), 64'd0);
        chk("t6_rst_upd", 64'({upd_valid, upd_result, mispredict}), 64'd0);
        chk("t6_rst_upd_pc", 64'(upd_PC), 64'd0);
        chk("t6_rst_counts", 64'({branch_count, mispredict_count}), 64'd0);
        chk("t6_rst_errs", 64'({overflow_err, underflow_err}), 64'd0);
        chk("t6_rst_ready", 64'(pred_ready), 64'd1);

        step();
        step();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
